// File: rtl/sar_decimator.sv
// Averages SAR conversion words over 1/2/4/8-sample windows and queues the
// truncated means in a small result FIFO with a ready/valid read side.
module sar_decimator #(
  parameter int DW         = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK_S,
  input  logic                          RST,
  input  logic                          EN,
  input  logic                          EOC,
  input  logic [DW-1:0]                 DIN,
  input  logic [1:0]                    AVG_LOG2,
  input  logic                          CLR_OVF,
  input  logic                          RDY,
  output logic                          VLD,
  output logic [DW-1:0]                 DATA,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic                          OVF,
  output logic                          BUSY,
  output logic [15:0]                   SAMPLE_CNT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  logic          eoc_q;
  logic [DW+2:0] acc;
  logic [2:0]    win_cnt;
  logic [1:0]    win_sel;
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          ovf;
  logic [15:0]   sample_cnt;

  logic          sample;
  logic [1:0]    eff_sel;
  logic [2:0]    win_last;
  logic          last;
  logic [DW+2:0] sum;
  logic [DW-1:0] result;
  logic          push;
  logic          pop;
  logic          full;
  logic          wr_ok;

  // The first sample of a window sees the live AVG_LOG2, later ones the latched copy.
  always_comb begin
    sample  = EOC & ~eoc_q & EN;
    eff_sel = (win_cnt == 3'd0) ? AVG_LOG2 : win_sel;
    case (eff_sel)
      2'd0:    win_last = 3'd0;
      2'd1:    win_last = 3'd1;
      2'd2:    win_last = 3'd3;
      default: win_last = 3'd7;
    endcase
    last = (win_cnt == win_last);
    sum  = acc + {3'b000, DIN};
    case (eff_sel)
      2'd0:    result = sum[DW-1:0];
      2'd1:    result = sum[DW:1];
      2'd2:    result = sum[DW+1:2];
      default: result = sum[DW+2:3];
    endcase
    push  = sample & last;
    pop   = VLD & RDY;
    full  = (level == FULL_LVL);
    wr_ok = push & (~full | pop);
  end

  always_ff @(posedge CLK_S) begin
    if (RST) begin
      eoc_q      <= 1'b1;
      acc        <= '0;
      win_cnt    <= '0;
      win_sel    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      ovf        <= 1'b0;
      sample_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      eoc_q <= EOC;
      if (!EN) begin
        acc     <= '0;
        win_cnt <= '0;
      end else if (sample) begin
        sample_cnt <= sample_cnt + 16'd1;
        if (win_cnt == 3'd0) win_sel <= AVG_LOG2;
        if (last) begin
          acc     <= '0;
          win_cnt <= '0;
        end else begin
          acc     <= sum;
          win_cnt <= win_cnt + 3'd1;
        end
      end

      // When full, a simultaneous pop frees the slot the write pointer now targets.
      if (wr_ok) begin
        mem[wr_ptr] <= result;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);

      case ({wr_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      if (push && full && !pop) ovf <= 1'b1;
      else if (CLR_OVF)         ovf <= 1'b0;
    end
  end

  assign VLD        = (level != '0);
  assign DATA       = mem[rd_ptr];
  assign LEVEL      = level;
  assign OVF        = ovf;
  assign BUSY       = (win_cnt != 3'd0);
  assign SAMPLE_CNT = sample_cnt;

endmodule

// File: tb/tb_sar_decimator.sv
// Scoreboard bench for sar_decimator: expected means are queued as samples are
// driven and checked when the DUT hands them over on VLD&RDY.
module tb_sar_decimator;

  localparam int DW = 10;
  localparam int FD = 4;

  logic          CLK_S = 1'b0;
  logic          RST;
  logic          EN;
  logic          EOC;
  logic [DW-1:0] DIN;
  logic [1:0]    AVG_LOG2;
  logic          CLR_OVF;
  logic          RDY;
  logic          VLD;
  logic [DW-1:0] DATA;
  logic [2:0]    LEVEL;
  logic          OVF;
  logic          BUSY;
  logic [15:0]   SAMPLE_CNT;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  logic [DW-1:0] sb_q[$];

  sar_decimator #(.DW(DW), .FIFO_DEPTH(FD)) dut (
    .CLK_S(CLK_S), .RST(RST), .EN(EN), .EOC(EOC), .DIN(DIN),
    .AVG_LOG2(AVG_LOG2), .CLR_OVF(CLR_OVF), .RDY(RDY),
    .VLD(VLD), .DATA(DATA), .LEVEL(LEVEL), .OVF(OVF), .BUSY(BUSY),
    .SAMPLE_CNT(SAMPLE_CNT)
  );

  always #5 CLK_S = ~CLK_S;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_S);
    #1;
  endtask

  task automatic pulse(input logic [DW-1:0] d);
    EOC = 1'b1;
    DIN = d;
    if (EN) exp_cnt++;
    step();
    EOC = 1'b0;
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && LEVEL != 0; i++) step();
    chk("drain_level", LEVEL, 0);
  endtask

  // Inputs change just after posedge, so negedge sees what the next edge will use.
  always @(negedge CLK_S) begin
    if (!RST && VLD && RDY) begin
      if (sb_q.size() == 0) chk("sb_extra", VLD, 0);
      else chk("sb_data", DATA, sb_q.pop_front());
    end
  end

  initial begin
    RST = 1'b1; EN = 1'b1; EOC = 1'b0; DIN = '0; AVG_LOG2 = 2'd0;
    CLR_OVF = 1'b0; RDY = 1'b1;
    repeat (3) step();
    chk("rst_vld", VLD, 0);
    chk("rst_level", LEVEL, 0);
    chk("rst_data", DATA, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_cnt", SAMPLE_CNT, 0);
    RST = 1'b0;
    step();

    // Pass-through with one-cycle latency
    EOC = 1'b1; DIN = 10'h2A5; exp_cnt++;
    sb_q.push_back(10'h2A5);
    step();
    chk("pt_vld", VLD, 1);
    EOC = 1'b0;
    step();
    chk("pt_cnt", SAMPLE_CNT, exp_cnt);
    drain();

    // Window of four; AVG_LOG2 change mid-window must not matter
    AVG_LOG2 = 2'd2;
    pulse(10'd100);
    chk("w4_busy1", BUSY, 1);
    AVG_LOG2 = 2'd0;
    pulse(10'd101);
    chk("w4_busy2", BUSY, 1);
    pulse(10'd102);
    chk("w4_busy3", BUSY, 1);
    sb_q.push_back(10'd101);
    pulse(10'd103);
    chk("w4_busy4", BUSY, 0);
    drain();

    // Fill, overflow, push+pop at full, drain, clear
    AVG_LOG2 = 2'd0;
    RDY = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) sb_q.push_back(DW'(i));
      pulse(DW'(i));
    end
    chk("ovf_level", LEVEL, 4);
    chk("ovf_flag", OVF, 1);
    chk("ovf_hold", DATA, 1);
    RDY = 1'b1; EOC = 1'b1; DIN = 10'd6; exp_cnt++;
    sb_q.push_back(10'd6);
    step();
    chk("full_pp_level", LEVEL, 4);
    EOC = 1'b0;
    drain();
    chk("ovf_sticky", OVF, 1);
    CLR_OVF = 1'b1;
    step();
    CLR_OVF = 1'b0;
    chk("ovf_clr", OVF, 0);

    // Full-scale window of eight
    AVG_LOG2 = 2'd3;
    sb_q.push_back(10'h3FF);
    for (int i = 0; i < 8; i++) pulse(10'h3FF);
    drain();

    // EN low discards a partial window
    AVG_LOG2 = 2'd2;
    pulse(10'd50);
    pulse(10'd60);
    EN = 1'b0;
    step();
    EN = 1'b1;
    chk("en_busy", BUSY, 0);
    chk("en_level", LEVEL, 0);
    sb_q.push_back(10'd8);
    for (int i = 0; i < 4; i++) pulse(10'd8);
    drain();
    chk("cnt_total", SAMPLE_CNT, exp_cnt);

    // Reset with queued results, partial window and EOC held high
    RDY = 1'b0; AVG_LOG2 = 2'd0;
    pulse(10'd9);
    pulse(10'd10);
    AVG_LOG2 = 2'd2;
    pulse(10'd11);
    EOC = 1'b1; RST = 1'b1;
    sb_q.delete();
    exp_cnt = 0;
    step();
    step();
    chk("rst2_level", LEVEL, 0);
    chk("rst2_busy", BUSY, 0);
    RST = 1'b0;
    repeat (3) step();
    chk("eochi_level", LEVEL, 0);
    chk("eochi_cnt", SAMPLE_CNT, 0);
    EOC = 1'b0; RDY = 1'b1; AVG_LOG2 = 2'd0;
    step();
    sb_q.push_back(10'd7);
    pulse(10'd7);
    drain();
    chk("post_cnt", SAMPLE_CNT, exp_cnt);
    chk("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
